// File: rtl/wb_register_file.sv
// Eight-entry write-back register file with a per-register pending scoreboard.
// Two registered read ports forward same-edge write-back data.
module wb_register_file #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] ans_wb,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  output logic          rd_ready_a,
  output logic          rd_ready_b,
  output logic [AW:0]   pend_cnt,
  output logic          wb_err
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [AW:0]      w_pend_cnt;
  logic             w_wb_act;
  logic             w_iss_act;
  logic             w_hit_a;
  logic             w_hit_b;
  logic [DW-1:0]    w_data_a;
  logic [DW-1:0]    w_data_b;
  logic             w_ready_a;
  logic             w_ready_b;

  assign w_wb_act  = wb_en && (wb_addr != '0);
  assign w_iss_act = iss_en && (iss_addr != '0);
  assign w_hit_a   = w_wb_act && (wb_addr == rd_addr_a);
  assign w_hit_b   = w_wb_act && (wb_addr == rd_addr_b);

  // Issue is applied after the clear so a same-edge new producer stays pending.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_wb_act)  w_pend_nxt[wb_addr]  = 1'b0;
    if (w_iss_act) w_pend_nxt[iss_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_pend_cnt = w_pend_cnt + (AW+1)'(w_pend_nxt[i]);
  end

  always_comb begin
    w_data_a  = '0;
    w_ready_a = 1'b1;
    if (rd_addr_a != '0) begin
      w_data_a  = w_hit_a ? ans_wb : r_regs[rd_addr_a];
      w_ready_a = ~r_pending[rd_addr_a] | w_hit_a;
    end
  end

  always_comb begin
    w_data_b  = '0;
    w_ready_b = 1'b1;
    if (rd_addr_b != '0) begin
      w_data_b  = w_hit_b ? ans_wb : r_regs[rd_addr_b];
      w_ready_b = ~r_pending[rd_addr_b] | w_hit_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_pending  <= '0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      rd_ready_a <= 1'b1;
      rd_ready_b <= 1'b1;
      pend_cnt   <= '0;
      wb_err     <= 1'b0;
    end else begin
      if (w_wb_act) r_regs[wb_addr] <= ans_wb;
      r_pending  <= w_pend_nxt;
      rd_data_a  <= w_data_a;
      rd_data_b  <= w_data_b;
      rd_ready_a <= w_ready_a;
      rd_ready_b <= w_ready_b;
      pend_cnt   <= w_pend_cnt;
      if (w_wb_act && !r_pending[wb_addr]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Directed self-checking bench for wb_register_file.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] ans_wb;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        rd_ready_a;
  logic        rd_ready_b;
  logic [3:0]  pend_cnt;
  logic        wb_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_register_file #(.DW(16), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .wb_en(wb_en), .wb_addr(wb_addr), .ans_wb(ans_wb),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
    .pend_cnt(pend_cnt), .wb_err(wb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    wb_en = 1'b0; wb_addr = '0; ans_wb = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wb_en = 1'b0; wb_addr = '0; ans_wb = '0; iss_en = 1'b0; iss_addr = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    tick(); tick();
    @(negedge clk); reset = 1'b1;
    tick();
    total_cnt++; if (rd_ready_a !== 1'b1 || rd_ready_b !== 1'b1) $display("FAIL por_ready a=%b b=%b exp=1", rd_ready_a, rd_ready_b); else pass_cnt++;
    total_cnt++; if (pend_cnt !== 4'd0 || wb_err !== 1'b0) $display("FAIL por_cnt_err cnt=%0d err=%b exp=0/0", pend_cnt, wb_err); else pass_cnt++;
    // build up state: R1 written (sets wb_err), R3 left pending
    idle(); iss_en = 1'b1; iss_addr = 3'd3;
    tick();
    idle(); wb_en = 1'b1; wb_addr = 3'd1; ans_wb = 16'hAAAA; rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    tick();
    total_cnt++; if (rd_data_a !== 16'hAAAA || pend_cnt !== 4'd1 || rd_ready_b !== 1'b0) $display("FAIL pre_reset data=%h cnt=%0d rdyb=%b exp=aaaa/1/0", rd_data_a, pend_cnt, rd_ready_b); else pass_cnt++;
    idle();
    #2 reset = 1'b0;
    #1;
    total_cnt++; if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) $display("FAIL async_data a=%h b=%h exp=0", rd_data_a, rd_data_b); else pass_cnt++;
    total_cnt++; if (rd_ready_a !== 1'b1 || rd_ready_b !== 1'b1 || pend_cnt !== 4'd0 || wb_err !== 1'b0) $display("FAIL async_flags rdy=%b%b cnt=%0d err=%b exp=11/0/0", rd_ready_a, rd_ready_b, pend_cnt, wb_err); else pass_cnt++;
    // write-back while reset is still held must be ignored
    wb_en = 1'b1; wb_addr = 3'd6; ans_wb = 16'h6666;
    tick();
    idle(); reset = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    tick();
    total_cnt++; if (rd_data_a !== 16'h0 || rd_ready_b !== 1'b1) $display("FAIL post_reset r1=%h r3rdy=%b exp=0/1", rd_data_a, rd_ready_b); else pass_cnt++;
    idle(); rd_addr_a = 3'd6;
    tick();
    total_cnt++; if (rd_data_a !== 16'h0 || wb_err !== 1'b0) $display("FAIL wb_in_reset r6=%h err=%b exp=0/0", rd_data_a, wb_err); else pass_cnt++;
  endtask

  task automatic test_write_read();
    idle(); iss_en = 1'b1; iss_addr = 3'd5;
    tick();
    idle(); wb_en = 1'b1; wb_addr = 3'd5; ans_wb = 16'hBEEF; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    tick();
    total_cnt++; if (rd_data_a !== 16'hBEEF || rd_ready_a !== 1'b1) $display("FAIL wr_bypass data=%h rdy=%b exp=beef/1", rd_data_a, rd_ready_a); else pass_cnt++;
    total_cnt++; if (rd_data_b !== 16'hBEEF || rd_ready_b !== 1'b1) $display("FAIL wr_bypass_b data=%h rdy=%b exp=beef/1", rd_data_b, rd_ready_b); else pass_cnt++;
    idle();
    tick();
    total_cnt++; if (rd_data_a !== 16'hBEEF || rd_ready_a !== 1'b1 || wb_err !== 1'b0) $display("FAIL wr_storage data=%h rdy=%b err=%b exp=beef/1/0", rd_data_a, rd_ready_a, wb_err); else pass_cnt++;
    total_cnt++; if (rd_data_b !== 16'hBEEF || pend_cnt !== 4'd0) $display("FAIL wr_storage_b data=%h cnt=%0d exp=beef/0", rd_data_b, pend_cnt); else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    idle(); iss_en = 1'b1; iss_addr = 3'd2; rd_addr_b = 3'd2;
    tick();
    total_cnt++; if (rd_ready_b !== 1'b1 || pend_cnt !== 4'd1) $display("FAIL sb_issue_edge rdy=%b cnt=%0d exp=1/1", rd_ready_b, pend_cnt); else pass_cnt++;
    idle();
    for (int e = 2; e <= 4; e++) begin
      tick();
      total_cnt++; if (rd_ready_b !== 1'b0 || pend_cnt !== 4'd1) $display("FAIL sb_pending_e%0d rdy=%b cnt=%0d exp=0/1", e, rd_ready_b, pend_cnt); else pass_cnt++;
    end
    idle(); wb_en = 1'b1; wb_addr = 3'd2; ans_wb = 16'h0042;
    tick();
    total_cnt++; if (rd_data_b !== 16'h0042 || rd_ready_b !== 1'b1 || pend_cnt !== 4'd0) $display("FAIL sb_clear data=%h rdy=%b cnt=%0d exp=0042/1/0", rd_data_b, rd_ready_b, pend_cnt); else pass_cnt++;
  endtask

  task automatic test_collision();
    idle(); iss_en = 1'b1; iss_addr = 3'd4;
    tick();
    idle(); iss_en = 1'b1; iss_addr = 3'd4; wb_en = 1'b1; wb_addr = 3'd4; ans_wb = 16'h1234; rd_addr_a = 3'd4;
    tick();
    total_cnt++; if (rd_data_a !== 16'h1234 || rd_ready_a !== 1'b1 || pend_cnt !== 4'd1) $display("FAIL col_edge data=%h rdy=%b cnt=%0d exp=1234/1/1", rd_data_a, rd_ready_a, pend_cnt); else pass_cnt++;
    idle();
    tick();
    total_cnt++; if (rd_data_a !== 16'h1234 || rd_ready_a !== 1'b0 || pend_cnt !== 4'd1) $display("FAIL col_after data=%h rdy=%b cnt=%0d exp=1234/0/1", rd_data_a, rd_ready_a, pend_cnt); else pass_cnt++;
    idle(); wb_en = 1'b1; wb_addr = 3'd4; ans_wb = 16'h1235;
    tick();
    total_cnt++; if (pend_cnt !== 4'd0 || wb_err !== 1'b0) $display("FAIL col_drain cnt=%0d err=%b exp=0/0", pend_cnt, wb_err); else pass_cnt++;
  endtask

  task automatic test_r0();
    idle(); iss_en = 1'b1; iss_addr = 3'd6;
    tick();
    idle(); wb_en = 1'b1; wb_addr = 3'd0; ans_wb = 16'hFFFF; iss_en = 1'b1; iss_addr = 3'd0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    tick();
    total_cnt++; if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || rd_ready_a !== 1'b1 || rd_ready_b !== 1'b1) $display("FAIL r0_edge data=%h/%h rdy=%b%b exp=0/0/11", rd_data_a, rd_data_b, rd_ready_a, rd_ready_b); else pass_cnt++;
    total_cnt++; if (pend_cnt !== 4'd1 || wb_err !== 1'b0) $display("FAIL r0_cnt_err cnt=%0d err=%b exp=1/0", pend_cnt, wb_err); else pass_cnt++;
    idle();
    tick();
    total_cnt++; if (rd_data_a !== 16'h0 || rd_ready_a !== 1'b1 || pend_cnt !== 4'd1) $display("FAIL r0_storage data=%h rdy=%b cnt=%0d exp=0/1/1", rd_data_a, rd_ready_a, pend_cnt); else pass_cnt++;
    idle(); wb_en = 1'b1; wb_addr = 3'd6; ans_wb = 16'h0606;
    tick();
  endtask

  task automatic test_error();
    idle(); wb_en = 1'b1; wb_addr = 3'd7; ans_wb = 16'h0001; rd_addr_a = 3'd7;
    tick();
    total_cnt++; if (wb_err !== 1'b1 || rd_data_a !== 16'h0001) $display("FAIL err_set err=%b data=%h exp=1/0001", wb_err, rd_data_a); else pass_cnt++;
    idle();
    tick();
    total_cnt++; if (wb_err !== 1'b1 || rd_data_a !== 16'h0001 || rd_ready_a !== 1'b1) $display("FAIL err_r7 err=%b data=%h rdy=%b exp=1/0001/1", wb_err, rd_data_a, rd_ready_a); else pass_cnt++;
    idle(); iss_en = 1'b1; iss_addr = 3'd3;
    tick();
    idle(); wb_en = 1'b1; wb_addr = 3'd3; ans_wb = 16'h3333; rd_addr_b = 3'd3;
    tick();
    total_cnt++; if (wb_err !== 1'b1 || rd_data_b !== 16'h3333 || pend_cnt !== 4'd0) $display("FAIL err_sticky err=%b data=%h cnt=%0d exp=1/3333/0", wb_err, rd_data_b, pend_cnt); else pass_cnt++;
    idle(); reset = 1'b0;
    #1;
    total_cnt++; if (wb_err !== 1'b0) $display("FAIL err_reset err=%b exp=0", wb_err); else pass_cnt++;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_r0();
    test_error();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
